demultiplexador_quatro_reg: RTL and testbench
=============================================

Name: demultiplexador_quatro_reg

Overview:
- Registered 1-to-4 demultiplexer: the counterpart of the 4-to-1 data selector on the processor datapath.
- Accepts one data word per handshake on a single input channel and routes it by `selecao` into one of four output holding registers.
- Each output channel has its own valid/ready handshake toward its consumer (register-file write ports, I/O latches).
- Keeps a running count of accepted words.

Parameters:
- LARGURA, 8, data width in bits of `entrada` and each `saidaN`.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- selecao  input  2  destination channel of the current input word (00→0, 01→1, 10→2, 11→3).
- entrada  input  LARGURA  input data word.
- entrada_valida  input  1  producer asserts: `entrada`/`selecao` valid this cycle.
- entrada_pronta  output  1  block can accept the word addressed by `selecao` this cycle.
- saida0..saida3  output  LARGURA each  holding-register contents of channels 0..3.
- saida_valida  output  4  bit N = channel N holds an unconsumed word.
- saida_pronta  input  4  bit N = consumer N takes the word this cycle.
- contador  output  8  number of accepted input words, modulo 256.

Behaviour:
- Reset (reset=1 at a rising edge) has priority over all other activity:
  - saida0..3 = 0, saida_valida = 4'b0000, contador = 0.
  - A word in flight is discarded; no handshake completes in a reset cycle.
- Per-channel state machine, N = 0..3, with two states:
  - VAZIO (saida_valida[N]=0): channel is empty.
  - CHEIO (saida_valida[N]=1): channel holds an unconsumed word.
- Handshake signals:
  - entrada_pronta = ~saida_valida[selecao] | saida_pronta[selecao]. This is combinational and depends only on `selecao` and the addressed channel's state and ready. It is not gated by entrada_valida.
  - Input accept = entrada_valida & entrada_pronta. The word is committed at the next rising edge.
  - Output consume on channel N = saida_valida[N] & saida_pronta[N].
- Transitions per channel N, where load_N = accept & (selecao==N):
  - VAZIO, load_N → CHEIO; saidaN ← entrada.
  - CHEIO, consume_N and not load_N → VAZIO; saidaN holds its old value, not cleared.
  - CHEIO, consume_N and load_N → stays CHEIO; saidaN ← entrada. This is pass-through: no bubble, one word per cycle per channel sustained.
  - CHEIO, no consume → stays CHEIO; a load is impossible because entrada_pronta=0.
  - saida_pronta[N] while VAZIO is ignored.
- Latency: a word accepted at edge k appears on saidaN with saida_valida[N]=1 immediately after edge k (one-cycle registered latency).
- Channel independence: a full, stalled channel never blocks words addressed to other channels. Consumers on different channels may consume in the same cycle as a load on another channel.
- contador increments by 1 on every accept and wraps from 255 to 0. A consume alone never changes contador.
- Blocked cycle (entrada_valida=1, entrada_pronta=0): no state changes. The producer must hold `entrada`/`selecao` stable. If `selecao` changes anyway, the new value is evaluated that cycle; no error is raised.
- A `selecao` change while entrada_valida=0 has no effect on state.

Optional Feature:
- Macro: DEMUX_BLOQUEIOS_EN.
- Defined: adds output port `bloqueios` (8 bits), a saturating counter.
  - Increments on every cycle with entrada_valida=1 and entrada_pronta=0.
  - Holds at 255; does not wrap.
  - Reset to 0 by reset.
- Not defined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset: drive reset=1 for 2 cycles with entrada_valida=1 → saida_valida=0000, saida0..3=0, contador=0, nothing loaded.
- Routing: with all saida_pronta=0, send 0x00 (sel 00), 0x01 (sel 01), 0x02 (sel 10), 0x80 (sel 11) on consecutive cycles → saida0..3 = 00,01,02,80; saida_valida=1111; contador=4.
- Stall: channel 2 full with 0x02, saida_pronta[2]=0; present 0x55 on sel 10 for 3 cycles → entrada_pronta=0, saida2 stays 0x02; with DEMUX_BLOQUEIOS_EN, bloqueios=3.
  - Then raise saida_pronta[2] → 0x55 loads next edge and saida_valida[2] stays 1.
- Pass-through: saida_pronta[1]=1 continuously; stream 0x10,0x11,0x12 to sel 01 on back-to-back cycles → entrada_pronta=1 every cycle, saida1 shows 10,11,12 on consecutive cycles, contador +3.
- Independence: channel 0 full and stalled; send 0xAA to sel 11 → accepted, saida3=0xAA, saida0 unchanged.
- Wrap/saturation: 257 accepts → contador=1; 300 blocked cycles → bloqueios=255 (macro defined).

Source files
------------

// File: rtl/demultiplexador_quatro_reg.sv
// Registered 1-to-4 demultiplexer: one input word per handshake, steered by selecao into
// one of four holding registers, each with its own valid/ready toward its consumer.
// Optional saturating blocked-cycle counter on port bloqueios when DEMUX_BLOQUEIOS_EN is defined.
module demultiplexador_quatro_reg #(
   parameter int LARGURA = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [1:0]         selecao,
   input  logic [LARGURA-1:0] entrada,
   input  logic               entrada_valida,
   output logic               entrada_pronta,
   output logic [LARGURA-1:0] saida0,
   output logic [LARGURA-1:0] saida1,
   output logic [LARGURA-1:0] saida2,
   output logic [LARGURA-1:0] saida3,
   output logic [3:0]         saida_valida,
   input  logic [3:0]         saida_pronta,
   output logic [7:0]         contador
`ifdef DEMUX_BLOQUEIOS_EN
   ,
   output logic [7:0]         bloqueios
`endif
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // entrada_pronta looks only at the addressed channel and never depends on entrada_valida;
   // saida_valida[N] is the per-channel state itself (1 = CHEIO) and never depends on saida_pronta.
   typedef enum logic {
      VAZIO = 1'b0,
      CHEIO = 1'b1
   } estado_t;

   logic                w_aceite;
   logic [LARGURA-1:0]  w_dado [4];
   logic [7:0]          r_contador;

   assign entrada_pronta = ~saida_valida[selecao] | saida_pronta[selecao];
   assign w_aceite       = entrada_valida & entrada_pronta;

   for (genvar n = 0; n < 4; n++) begin : g_canal
      localparam logic [1:0] CANAL = 2'(n);

      estado_t            r_estado;
      estado_t            w_prox_estado;
      logic [LARGURA-1:0] r_dado;
      logic               w_carga;
      logic               w_consumo;

      assign w_carga   = w_aceite & (selecao == CANAL);
      assign w_consumo = (r_estado == CHEIO) & saida_pronta[n];

      always_ff @(posedge clock) begin
         if (reset) begin
            r_estado <= VAZIO;
         end else begin
            r_estado <= w_prox_estado;
         end
      end

      // A load while CHEIO only happens together with a consume: pass-through, stays CHEIO.
      always_comb begin
         w_prox_estado = r_estado;
         case (r_estado)
            VAZIO:   if (w_carga) w_prox_estado = CHEIO;
            CHEIO:   if (w_consumo && !w_carga) w_prox_estado = VAZIO;
            default: w_prox_estado = VAZIO;
         endcase
      end

      // The data register keeps its last word after a consume; only a load overwrites it.
      always_ff @(posedge clock) begin
         if (reset) begin
            r_dado <= '0;
         end else if (w_carga) begin
            r_dado <= entrada;
         end
      end

      assign saida_valida[n] = (r_estado == CHEIO);
      assign w_dado[n]       = r_dado;
   end

   assign saida0 = w_dado[0];
   assign saida1 = w_dado[1];
   assign saida2 = w_dado[2];
   assign saida3 = w_dado[3];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_contador <= 8'd0;
      end else if (w_aceite) begin
         r_contador <= r_contador + 8'd1;
      end
   end

   assign contador = r_contador;

`ifdef DEMUX_BLOQUEIOS_EN
   logic       w_bloqueado;
   logic [7:0] r_bloqueios;

   assign w_bloqueado = entrada_valida & ~entrada_pronta;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_bloqueios <= 8'd0;
      end else if (w_bloqueado && (r_bloqueios != 8'hFF)) begin
         r_bloqueios <= r_bloqueios + 8'd1;
      end
   end

   assign bloqueios = r_bloqueios;
`endif

endmodule

// File: tb/tb_demultiplexador_quatro_reg.sv
// Self-checking bench for demultiplexador_quatro_reg: directed scenarios plus random
// traffic checked against a per-channel occupancy model and per-channel word queues.
module tb_demultiplexador_quatro_reg;

   localparam int LARGURA = 8;

   logic               clock;
   logic               reset;
   logic [1:0]         selecao;
   logic [LARGURA-1:0] entrada;
   logic               entrada_valida;
   logic               entrada_pronta;
   logic [LARGURA-1:0] saida0, saida1, saida2, saida3;
   logic [3:0]         saida_valida;
   logic [3:0]         saida_pronta;
   logic [7:0]         contador;
`ifdef DEMUX_BLOQUEIOS_EN
   logic [7:0]         bloqueios;
`endif

   demultiplexador_quatro_reg #(.LARGURA(LARGURA)) dut (
      .clock          (clock),
      .reset          (reset),
      .selecao        (selecao),
      .entrada        (entrada),
      .entrada_valida (entrada_valida),
      .entrada_pronta (entrada_pronta),
      .saida0         (saida0),
      .saida1         (saida1),
      .saida2         (saida2),
      .saida3         (saida3),
      .saida_valida   (saida_valida),
      .saida_pronta   (saida_pronta),
      .contador       (contador)
`ifdef DEMUX_BLOQUEIOS_EN
      ,
      .bloqueios      (bloqueios)
`endif
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // scoreboard
   int n_checks = 0;
   int n_fails  = 0;

   logic [LARGURA-1:0] exp_q [4][$];
   bit                 mdl_cheio [4];
   logic [LARGURA-1:0] mdl_dado [4];
   int                 mdl_cont;
   int                 mdl_bloq;
   logic [LARGURA-1:0] obs_saida [4];

   assign obs_saida[0] = saida0;
   assign obs_saida[1] = saida1;
   assign obs_saida[2] = saida2;
   assign obs_saida[3] = saida3;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] exp_v;
      for (int n = 0; n < 4; n++) exp_v[n] = mdl_cheio[n];
      check({tag, "_valida"}, {28'd0, saida_valida}, {28'd0, exp_v});
      for (int n = 0; n < 4; n++)
         check($sformatf("%s_saida%0d", tag, n), {24'd0, obs_saida[n]}, {24'd0, mdl_dado[n]});
      check({tag, "_contador"}, {24'd0, contador}, mdl_cont);
`ifdef DEMUX_BLOQUEIOS_EN
      check({tag, "_bloqueios"}, {24'd0, bloqueios}, mdl_bloq);
`endif
   endtask

   // driver tasks
   task automatic do_reset();
      reset          = 1'b1;
      entrada_valida = 1'b1;
      selecao        = 2'($urandom_range(0, 3));
      entrada        = 8'($urandom);
      saida_pronta   = 4'($urandom);
      repeat (2) @(posedge clock);
      #1;
      reset          = 1'b0;
      entrada_valida = 1'b0;
      saida_pronta   = 4'b0000;
      for (int n = 0; n < 4; n++) begin
         mdl_cheio[n] = 1'b0;
         mdl_dado[n]  = '0;
         exp_q[n].delete();
      end
      mdl_cont = 0;
      mdl_bloq = 0;
      check_outputs("reset");
   endtask

   // One clock cycle: drive inputs, check the ready and any consumed word before the edge,
   // advance the model by the handshake rules, then check registered outputs after the edge.
   task automatic ciclo(input logic [1:0] sel, input logic [LARGURA-1:0] din,
                        input logic ev, input logic [3:0] rdy, input string tag);
      bit                 exp_pronta;
      bit                 aceite;
      bit                 consumo [4];
      logic [LARGURA-1:0] exp_w;
      selecao        = sel;
      entrada        = din;
      entrada_valida = ev;
      saida_pronta   = rdy;
      @(negedge clock);
      exp_pronta = !mdl_cheio[sel] || rdy[sel];
      check({tag, "_pronta"}, {31'd0, entrada_pronta}, {31'd0, exp_pronta});
      aceite = ev && exp_pronta;
      for (int n = 0; n < 4; n++) begin
         consumo[n] = mdl_cheio[n] && rdy[n];
         if (consumo[n]) begin
            if (exp_q[n].size() == 0) begin
               check($sformatf("%s_fila%0d", tag, n), 32'd0, 32'd1);
            end else begin
               exp_w = exp_q[n].pop_front();
               check($sformatf("%s_consumo%0d", tag, n), {24'd0, obs_saida[n]}, {24'd0, exp_w});
            end
         end
      end
      @(posedge clock);
      #1;
      for (int n = 0; n < 4; n++) begin
         if (aceite && (int'(sel) == n)) begin
            mdl_cheio[n] = 1'b1;
            mdl_dado[n]  = din;
            exp_q[n].push_back(din);
         end else if (consumo[n]) begin
            mdl_cheio[n] = 1'b0;
         end
      end
      if (aceite) mdl_cont = (mdl_cont + 1) % 256;
      if (ev && !exp_pronta && mdl_bloq < 255) mdl_bloq++;
      check_outputs(tag);
   endtask

   initial begin
      reset          = 1'b0;
      selecao        = 2'd0;
      entrada        = '0;
      entrada_valida = 1'b0;
      saida_pronta   = 4'b0000;
      @(negedge clock);
      do_reset();
      check("reset_const_valida", {28'd0, saida_valida}, 32'd0);
      check("reset_const_contador", {24'd0, contador}, 32'd0);

      // routing into all four channels, no consumers ready
      ciclo(2'd0, 8'h00, 1'b1, 4'b0000, "rota0");
      ciclo(2'd1, 8'h01, 1'b1, 4'b0000, "rota1");
      ciclo(2'd2, 8'h02, 1'b1, 4'b0000, "rota2");
      ciclo(2'd3, 8'h80, 1'b1, 4'b0000, "rota3");
      check("rota_const_s3", {24'd0, saida3}, 32'h80);
      check("rota_const_valida", {28'd0, saida_valida}, 32'hF);
      check("rota_const_contador", {24'd0, contador}, 32'd4);

      // stall on full channel 2, then release it
      repeat (3) ciclo(2'd2, 8'h55, 1'b1, 4'b0000, "parada");
      check("parada_const_s2", {24'd0, saida2}, 32'h02);
`ifdef DEMUX_BLOQUEIOS_EN
      check("parada_const_bloqueios", {24'd0, bloqueios}, 32'd3);
`endif
      ciclo(2'd2, 8'h55, 1'b1, 4'b0100, "libera");
      check("libera_const_s2", {24'd0, saida2}, 32'h55);

      // sustained pass-through on channel 1
      ciclo(2'd1, 8'h10, 1'b1, 4'b0010, "passa0");
      ciclo(2'd1, 8'h11, 1'b1, 4'b0010, "passa1");
      ciclo(2'd1, 8'h12, 1'b1, 4'b0010, "passa2");
      check("passa_const_s1", {24'd0, saida1}, 32'h12);
      check("passa_const_contador", {24'd0, contador}, 32'd8);

      // independence: drain channel 3, then load it while channel 0 stays full and stalled
      ciclo(2'd0, 8'h00, 1'b0, 4'b1000, "drena3");
      ciclo(2'd3, 8'hAA, 1'b1, 4'b0000, "indep");
      check("indep_const_s3", {24'd0, saida3}, 32'hAA);
      check("indep_const_s0", {24'd0, saida0}, 32'h00);

      // counter wrap
      do_reset();
      for (int i = 0; i < 257; i++)
         ciclo(2'($urandom_range(0, 3)), 8'($urandom), 1'b1, 4'b1111, "volta");
      check("volta_const_contador", {24'd0, contador}, 32'd1);

      // blocked-cycle saturation
      ciclo(2'd0, 8'h33, 1'b1, 4'b0000, "enche0");
      for (int i = 0; i < 300; i++)
         ciclo(2'd0, 8'($urandom), 1'b1, 4'b0000, "satura");
`ifdef DEMUX_BLOQUEIOS_EN
      check("satura_const_bloqueios", {24'd0, bloqueios}, 32'd255);
`endif

      // random traffic
      do_reset();
      for (int i = 0; i < 400; i++)
         ciclo(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 3) != 0),
               4'($urandom), "aleat");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
